// File: rtl/raster_pkg.sv
// Shared definitions for the raster back end: depth-buffer sizing, the
// far-plane clear value and the depth-test FSM states.
package raster_pkg;

  typedef enum logic {CLEAR, RUN} zstate_e;

  function automatic int depth_addr_w(input int hres, input int vres);
    return $clog2(hres * vres);
  endfunction

  // Most-positive signed value of the given width, used as the cleared depth.
  function automatic logic [63:0] z_far_value(input int w);
    return (64'(1) << (w - 1)) - 64'(1);
  endfunction

endpackage

// File: rtl/depth_ram.sv
// Simple dual-port depth buffer: one write port, one enabled read port whose
// data arrives two enabled cycles after the address.
module depth_ram #(
  parameter int DW    = 16,
  parameter int DEPTH = 57600,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd1_q, rd2_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Both read stages hold together when the consumer stalls.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd1_q <= '0;
      rd2_q <= '0;
    end else if (re_i) begin
      rd1_q <= mem[raddr_i];
      rd2_q <= rd1_q;
    end
  end

  assign rdata_o = rd2_q;

endmodule

// File: rtl/z_depth_test.sv
// Per-pixel depth test: three-stage pipeline against a frame-sized depth
// buffer, with write forwarding, backpressure and a between-frames clear.
module z_depth_test
  import raster_pkg::*;
#(
  parameter int ZWIDTH  = 16,
  parameter int FB_HRES = 320,
  parameter int FB_VRES = 180,
  parameter logic signed [ZWIDTH-1:0] Z_FAR = ZWIDTH'(z_far_value(ZWIDTH))
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         clear_in,
  input  logic                         valid_in,
  output logic                         ready_out,
  input  logic [$clog2(FB_HRES)-1:0]   hcount_in,
  input  logic [$clog2(FB_VRES)-1:0]   vcount_in,
  input  logic signed [ZWIDTH-1:0]     z_in,
  input  logic                         last_pixel_in,
  input  logic                         ready_in,
  output logic                         valid_out,
  output logic [$clog2(FB_HRES)-1:0]   hcount_out,
  output logic [$clog2(FB_VRES)-1:0]   vcount_out,
  output logic signed [ZWIDTH-1:0]     z_out,
  output logic                         tri_done_out,
  output logic                         clearing_out
);

  localparam int HW    = $clog2(FB_HRES);
  localparam int VW    = $clog2(FB_VRES);
  localparam int DEPTH = FB_HRES * FB_VRES;
  localparam int AW    = depth_addr_w(FB_HRES, FB_VRES);
  localparam logic [HW-1:0] H_LAST = HW'(FB_HRES - 1);
  localparam logic [VW-1:0] V_LAST = VW'(FB_VRES - 1);
  localparam logic [AW-1:0] A_LAST = AW'(DEPTH - 1);

  typedef struct packed {
    logic          vld;
    logic          inr;
    logic          last;
    logic [AW-1:0] addr;
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic [ZWIDTH-1:0] z;
  } pix_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [ZWIDTH-1:0] z;
  } wr_t;

  zstate_e       state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic          pend_q, pend_d;
  pix_t          s0_q, s1_q, s2_q, s0_d;
  wr_t           h1_q, h2_q, wr_d;

  logic          stall, advance, accept, in_range, clear_req, pipe_empty, pass;
  logic [AW-1:0] addr_in;
  logic [ZWIDTH-1:0] rdata, stored;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [ZWIDTH-1:0] ram_wdata;

  assign stall      = valid_out && !ready_in;
  assign advance    = !stall;
  assign clear_req  = clear_in || pend_q;
  assign ready_out  = (state_q == RUN) && !stall && !clear_req;
  assign accept     = valid_in && ready_out;
  assign in_range   = (hcount_in <= H_LAST) && (vcount_in <= V_LAST);
  assign addr_in    = in_range ? (AW'(vcount_in) * AW'(FB_HRES) + AW'(hcount_in)) : '0;
  assign pipe_empty = !(s0_q.vld || s1_q.vld || s2_q.vld);

  always_comb begin
    s0_d = '{vld: accept, inr: in_range, last: last_pixel_in, addr: addr_in,
             h: hcount_in, v: vcount_in, z: z_in};
  end

  // h1/h2 remember the writes made on the last two advancing edges; those are
  // exactly the writes the RAM read of the pixel now in S2 could have missed.
  always_comb begin
    stored = rdata;
    if (h2_q.we && h2_q.addr == s2_q.addr) stored = h2_q.z;
    if (h1_q.we && h1_q.addr == s2_q.addr) stored = h1_q.z;
  end

  assign pass         = $signed(s2_q.z) < $signed(stored);
  assign valid_out    = s2_q.vld && s2_q.inr && pass;
  assign tri_done_out = s2_q.vld && s2_q.last && advance;
  assign hcount_out   = s2_q.h;
  assign vcount_out   = s2_q.v;
  assign z_out        = s2_q.z;
  assign clearing_out = (state_q == CLEAR);
  assign wr_d         = '{we: valid_out && advance, addr: s2_q.addr, z: s2_q.z};

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s0_q <= '0;
      s1_q <= '0;
      s2_q <= '0;
      h1_q <= '0;
      h2_q <= '0;
    end else if (advance) begin
      s0_q <= s0_d;
      s1_q <= s0_q;
      s2_q <= s1_q;
      h1_q <= wr_d;
      h2_q <= h1_q;
    end
  end

  always_comb begin
    ram_we    = clearing_out || wr_d.we;
    ram_waddr = clearing_out ? clr_addr_q : s2_q.addr;
    ram_wdata = clearing_out ? Z_FAR : s2_q.z;
  end

  depth_ram #(.DW(ZWIDTH), .DEPTH(DEPTH), .AW(AW)) u_depth_ram (
    .clk_i   (clk_in),
    .rst_n_i (rst_n_in),
    .re_i    (advance),
    .raddr_i (s0_q.addr),
    .rdata_o (rdata),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      pend_q     <= pend_d;
    end
  end

  // A clear request waits for in-flight pixels to retire before wiping the buffer.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    pend_d     = pend_q;
    unique case (state_q)
      CLEAR: begin
        if (clr_addr_q == A_LAST) begin
          state_d    = RUN;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + AW'(1);
        end
      end
      RUN: begin
        if (clear_req) begin
          if (pipe_empty) begin
            state_d = CLEAR;
            pend_d  = 1'b0;
          end else begin
            pend_d = 1'b1;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_z_depth_test.sv
// Self-checking bench for z_depth_test on a reduced 20x12 frame: vector table,
// scoreboard queues and hand-written clear/reset/backpressure sequences.
module tb_z_depth_test;

  localparam int HRES = 20;
  localparam int VRES = 12;
  localparam int NPIX = HRES * VRES;

  logic        clk_in = 1'b0;
  logic        rst_n_in, clear_in, valid_in, last_pixel_in, ready_in;
  logic [4:0]  hcount_in;
  logic [3:0]  vcount_in;
  logic [15:0] z_in;
  logic        ready_out, valid_out, tri_done_out, clearing_out;
  logic [4:0]  hcount_out;
  logic [3:0]  vcount_out;
  logic [15:0] z_out;

  int checks = 0;
  int errors = 0;
  int cycleCount = 0;
  bit latencyCheck = 1'b1;

  typedef struct { logic [4:0] h; logic [3:0] v; logic [15:0] z; int acc; } outRec_t;
  typedef struct { int acc; logic expValid; } triRec_t;
  typedef struct { logic [4:0] h; logic [3:0] v; logic [15:0] z; logic last; logic expPass; } vec_t;

  outRec_t outQ[$];
  triRec_t triQ[$];
  outRec_t oe;
  triRec_t te;
  vec_t    vecs[20];

  z_depth_test #(.ZWIDTH(16), .FB_HRES(HRES), .FB_VRES(VRES)) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .clear_in      (clear_in),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .hcount_in     (hcount_in),
    .vcount_in     (vcount_in),
    .z_in          (z_in),
    .last_pixel_in (last_pixel_in),
    .ready_in      (ready_in),
    .valid_out     (valid_out),
    .hcount_out    (hcount_out),
    .vcount_out    (vcount_out),
    .z_out         (z_out),
    .tri_done_out  (tri_done_out),
    .clearing_out  (clearing_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cycleCount++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: outputs and triangle-done pulses retire in acceptance order.
  always @(negedge clk_in) begin
    if (rst_n_in && valid_out && ready_in) begin
      if (outQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL out_unexpected: got pixel (%0d,%0d,0x%0h), wanted none",
                 hcount_out, vcount_out, z_out);
      end else begin
        oe = outQ.pop_front();
        checkOutput("out_pixel", {7'd0, hcount_out, vcount_out, z_out}, {7'd0, oe.h, oe.v, oe.z});
        if (latencyCheck) checkOutput("out_latency", cycleCount - oe.acc, 32'd2);
      end
    end
    if (rst_n_in && tri_done_out) begin
      if (triQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL tri_unexpected: got tri_done_out=1, wanted 0");
      end else begin
        te = triQ.pop_front();
        checkOutput("tri_valid", {31'd0, valid_out}, {31'd0, te.expValid});
        if (latencyCheck) checkOutput("tri_latency", cycleCount - te.acc, 32'd2);
      end
    end
  end

  task automatic applyStimulus(input logic [4:0] h, input logic [3:0] v, input logic [15:0] z,
                               input logic last, input logic expPass);
    int waitCnt = 0;
    valid_in      = 1'b1;
    hcount_in     = h;
    vcount_in     = v;
    z_in          = z;
    last_pixel_in = last;
    @(negedge clk_in);
    while (!ready_out && waitCnt < 100) begin
      waitCnt++;
      @(negedge clk_in);
    end
    if (!ready_out) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got ready_out=0 for 100 cycles, wanted 1");
    end else begin
      if (expPass) outQ.push_back('{h: h, v: v, z: z, acc: cycleCount + 1});
      if (last) triQ.push_back('{acc: cycleCount + 1, expValid: expPass});
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic idleInputs();
    valid_in      = 1'b0;
    last_pixel_in = 1'b0;
  endtask

  task automatic drainScoreboard(input string name);
    int n = 0;
    while ((outQ.size() != 0 || triQ.size() != 0) && n < 50) begin
      @(negedge clk_in);
      n++;
    end
    checkOutput(name, outQ.size() + triQ.size(), 32'd0);
    repeat (3) @(posedge clk_in);
    #1;
  endtask

  task automatic countClearing(output int n, output int qAtStart);
    int guard = 0;
    n = 0;
    @(negedge clk_in);
    while (!clearing_out && guard < 50) begin
      @(negedge clk_in);
      guard++;
    end
    qAtStart = outQ.size();
    while (clearing_out && guard < 2000) begin
      n++;
      @(negedge clk_in);
      guard++;
    end
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish by 500000, wanted finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, q, g;
    rst_n_in = 1'b0; clear_in = 1'b0; valid_in = 1'b0; last_pixel_in = 1'b0;
    ready_in = 1'b1; hcount_in = '0; vcount_in = '0; z_in = '0;

    vecs[0]  = '{5'd10, 4'd5,  16'h1000, 1'b0, 1'b1};
    vecs[1]  = '{5'd10, 4'd5,  16'h1000, 1'b0, 1'b0};
    vecs[2]  = '{5'd10, 4'd5,  16'h0FFF, 1'b0, 1'b1};
    vecs[3]  = '{5'd3,  4'd2,  16'h2000, 1'b0, 1'b1};
    vecs[4]  = '{5'd3,  4'd2,  16'h1000, 1'b0, 1'b1};
    vecs[5]  = '{5'd3,  4'd2,  16'h1800, 1'b0, 1'b0};
    vecs[6]  = '{5'd3,  4'd2,  16'h0800, 1'b0, 1'b1};
    vecs[7]  = '{5'd3,  4'd2,  16'h0800, 1'b0, 1'b0};
    vecs[8]  = '{5'd3,  4'd2,  16'h07FF, 1'b0, 1'b1};
    vecs[9]  = '{5'd5,  4'd5,  16'h3000, 1'b0, 1'b1};
    vecs[10] = '{5'd6,  4'd6,  16'h3000, 1'b0, 1'b1};
    vecs[11] = '{5'd5,  4'd5,  16'h3000, 1'b0, 1'b0};
    vecs[12] = '{5'd5,  4'd5,  16'h2FFF, 1'b0, 1'b1};
    vecs[13] = '{5'd10, 4'd5,  16'h2000, 1'b1, 1'b0};
    vecs[14] = '{5'd20, 4'd0,  16'h0001, 1'b0, 1'b0};
    vecs[15] = '{5'd31, 4'd15, 16'h0001, 1'b1, 1'b0};
    vecs[16] = '{5'd0,  4'd0,  16'h7FFD, 1'b0, 1'b1};
    vecs[17] = '{5'd0,  4'd0,  16'h8000, 1'b0, 1'b1};
    vecs[18] = '{5'd0,  4'd0,  16'h7FF0, 1'b0, 1'b0};
    vecs[19] = '{5'd19, 4'd11, 16'h0100, 1'b1, 1'b1};

    repeat (3) @(posedge clk_in);
    #1;
    checkOutput("reset_ready", {31'd0, ready_out}, 32'd0);
    checkOutput("reset_clearing", {31'd0, clearing_out}, 32'd1);
    checkOutput("reset_valid", {30'd0, valid_out, tri_done_out}, 32'd0);
    checkOutput("reset_data", {7'd0, hcount_out, vcount_out, z_out}, 32'd0);
    rst_n_in = 1'b1;
    countClearing(n, q);
    checkOutput("clear_cycles", n, NPIX);
    checkOutput("run_ready", {31'd0, ready_out}, 32'd1);

    $display("[TB] readback sweep of every address");
    for (int v = 0; v < VRES; v++)
      for (int h = 0; h < HRES; h++)
        applyStimulus(5'(h), 4'(v), 16'h7FFE, 1'b0, 1'b1);
    idleInputs();
    drainScoreboard("sweep_drain");

    $display("[TB] vector table");
    for (int i = 0; i < 20; i++)
      applyStimulus(vecs[i].h, vecs[i].v, vecs[i].z, vecs[i].last, vecs[i].expPass);
    idleInputs();
    drainScoreboard("table_drain");

    $display("[TB] backpressure");
    latencyCheck = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          applyStimulus(5'(i), 4'd8, 16'h0100 + 16'(i), 1'b0, 1'b1);
        idleInputs();
      end
      begin
        repeat (3) @(posedge clk_in);
        #1 ready_in = 1'b0;
        repeat (5) begin
          @(negedge clk_in);
          checkOutput("bp_ready_low", {30'd0, valid_out, ready_out}, 32'd2);
        end
        @(posedge clk_in);
        #1 ready_in = 1'b1;
      end
    join
    drainScoreboard("bp_drain");
    latencyCheck = 1'b1;
    for (int i = 0; i < 8; i++)
      applyStimulus(5'(i), 4'd8, 16'h0100 + 16'(i), 1'b0, 1'b0);
    applyStimulus(5'd0, 4'd8, 16'h00FF, 1'b0, 1'b1);
    idleInputs();
    drainScoreboard("bp_probe_drain");

    $display("[TB] clear while busy");
    applyStimulus(5'd1, 4'd1, 16'h0100, 1'b0, 1'b1);
    applyStimulus(5'd2, 4'd1, 16'h0100, 1'b0, 1'b1);
    idleInputs();
    clear_in = 1'b1;
    @(negedge clk_in);
    checkOutput("clr_req_ready", {31'd0, ready_out}, 32'd0);
    @(posedge clk_in);
    #1 clear_in = 1'b0;
    countClearing(n, q);
    checkOutput("clr_retired_first", q, 32'd0);
    checkOutput("clr_busy_cycles", n, NPIX);
    applyStimulus(5'd1, 4'd1, 16'h7FFE, 1'b0, 1'b1);
    applyStimulus(5'd2, 4'd1, 16'h7FFF, 1'b0, 1'b0);
    idleInputs();
    drainScoreboard("clr_drain");

    $display("[TB] async reset mid-pixel and mid-clear");
    ready_in = 1'b0;
    applyStimulus(5'd7, 4'd7, 16'h0100, 1'b1, 1'b1);
    idleInputs();
    g = 0;
    while (!valid_out && g < 20) begin
      @(negedge clk_in);
      g++;
    end
    checkOutput("stall_hold", {22'd0, valid_out, tri_done_out, hcount_out, vcount_out},
                {22'd0, 1'b1, 1'b0, 5'd7, 4'd7});
    #1 rst_n_in = 1'b0;
    #1;
    checkOutput("reset_mid_valid", {30'd0, valid_out, tri_done_out}, 32'd0);
    checkOutput("reset_mid_data", {7'd0, hcount_out, vcount_out, z_out}, 32'd0);
    checkOutput("reset_mid_state", {30'd0, clearing_out, ready_out}, 32'd2);
    outQ.delete();
    triQ.delete();
    ready_in = 1'b1;
    @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    repeat (100) @(negedge clk_in);
    #1 rst_n_in = 1'b0;
    #1;
    checkOutput("reset_midclear", {30'd0, clearing_out, ready_out}, 32'd2);
    @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    countClearing(n, q);
    checkOutput("restart_cycles", n, NPIX);
    applyStimulus(5'd7, 4'd7, 16'h7FFE, 1'b0, 1'b1);
    applyStimulus(5'd19, 4'd11, 16'h7FFF, 1'b0, 1'b0);
    applyStimulus(5'd19, 4'd11, 16'h7FFE, 1'b1, 1'b1);
    idleInputs();
    drainScoreboard("final_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
